// File: rtl/if_bus_if.sv
// ----------------------------------------------------------------------------
// if_bus_if
//   Instruction-fetch bus interface between the PC register and the
//   instruction bus. Runs one Wishbone-style single read per fetch, returns
//   the word to IF/ID and holds the pipeline (stallreq_o) while the fetch
//   is outstanding.
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   stall[5:0]    pipeline stall vector (bit0 = PC, bit1 = IF)
//   flush         pipeline flush, aborts the current fetch
//   cpu_ce_i      fetch enable from PC register
//   cpu_addr_i    fetch address (bits [1:0] ignored)
//   cpu_data_o    fetched instruction, 32'h0 (NOP) when nothing is valid
//   stallreq_o    stall request to the control module
//   wb_*          instruction bus master (read-only, full-word selects)
//   bus_err_o     one-cycle pulse on fetch timeout
//
// Build option
//   IF_BUS_TIMEOUT_EN : enables the BUSY watchdog (TIMEOUT_CYCLES, 1..255).
//                       Without it bus_err_o is tied 0 and BUSY waits forever.
// ----------------------------------------------------------------------------
module if_bus_if #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic        cpu_ce_i,
    input  logic [31:0] cpu_addr_i,
    output logic [31:0] cpu_data_o,
    output logic        stallreq_o,
    output logic [31:0] wb_adr_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        BUSY       = 2'd1,
        WAIT_STALL = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] rd_buf;
    logic        launch;
    logic        timeout;

    assign launch  = (state == IDLE) && cpu_ce_i && !flush;
    assign wb_we_o = 1'b0;

`ifdef IF_BUS_TIMEOUT_EN
    logic [7:0] wd_cnt;

    // Fires on the TIMEOUT_CYCLES-th BUSY cycle without ack; flush and ack
    // both take precedence over the watchdog.
    assign timeout = (state == BUSY) && !wb_ack_i && !flush &&
                     (wd_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt    <= '0;
            bus_err_o <= 1'b0;
        end else begin
            bus_err_o <= timeout;
            if (launch)
                wd_cnt <= '0;
            else if (state == BUSY && !wb_ack_i)
                wd_cnt <= wd_cnt + 8'd1;
        end
    end
`else
    logic unused_timeout_cfg;

    // The watchdog limit is only meaningful when the watchdog is built in.
    assign unused_timeout_cfg = |8'(TIMEOUT_CYCLES);
    assign timeout            = 1'b0;
    assign bus_err_o          = 1'b0;
`endif

    // State register and bus-side registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wb_adr_o <= '0;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_sel_o <= '0;
            rd_buf   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (launch) begin
                        wb_adr_o <= {cpu_addr_i[31:2], 2'b00};
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        wb_sel_o <= 4'hF;
                    end
                end
                BUSY: begin
                    if (flush || wb_ack_i || timeout) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_sel_o <= '0;
                    end
                    if (!flush && wb_ack_i)
                        rd_buf <= wb_dat_i;
                end
                default: ;
            endcase
        end
    end

    // Next state and combinational outputs. Reset masks the outputs so an
    // ack landing in the reset cycle never reaches IF/ID.
    always_comb begin
        state_nxt  = state;
        stallreq_o = 1'b0;
        cpu_data_o = '0;
        case (state)
            IDLE: begin
                if (launch)
                    state_nxt = BUSY;
                stallreq_o = launch;
            end
            BUSY: begin
                if (flush)
                    state_nxt = IDLE;
                else if (wb_ack_i)
                    state_nxt = (stall != 6'b0) ? WAIT_STALL : IDLE;
                else if (timeout)
                    state_nxt = IDLE;
                stallreq_o = !wb_ack_i && !flush && !timeout;
                if (wb_ack_i && !flush)
                    cpu_data_o = wb_dat_i;
            end
            WAIT_STALL: begin
                if (flush || stall == 6'b0)
                    state_nxt = IDLE;
                cpu_data_o = rd_buf;
            end
            default: state_nxt = IDLE;
        endcase
        if (rst) begin
            stallreq_o = 1'b0;
            cpu_data_o = '0;
        end
    end

endmodule

// File: tb/tb_if_bus_if.sv
module tb_if_bus_if;

`ifdef IF_BUS_TIMEOUT_EN
    localparam int unsigned TO = 4;
`else
    localparam int unsigned TO = 255;
`endif

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        cpu_ce_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_data_o;
    logic        stallreq_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        bus_err_o;

    if_bus_if #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .cpu_ce_i   (cpu_ce_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_data_o (cpu_data_o),
        .stallreq_o (stallreq_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_sel_o   (wb_sel_o),
        .bus_err_o  (bus_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=expired required=event at %0t", name, $time);
    endtask

    // Instruction memory seen by the slave; never returns 0 so a delivered
    // word is always distinguishable from the NOP.
    function automatic logic [31:0] mem(input logic [31:0] a);
        case (a)
            32'h0000_0104: mem = 32'h3C01_1234;
            32'h0000_0004: mem = 32'h2402_0005;
            default:       mem = ((a ^ 32'hA5A5_0000) * 32'h9E37_79B1) | 32'h1;
        endcase
    endfunction

    // ---------------- bus slave ----------------
    int unsigned waitq[$];
    logic        slave_hold = 1'b0;
    logic        spurious   = 1'b0;
    logic        in_cyc     = 1'b0;
    int unsigned wcnt       = 0;

    initial begin
        wb_ack_i = 1'b0;
        wb_dat_i = '0;
    end

    always @(posedge clk) begin
        #1;
        if (wb_cyc_o && wb_stb_o) begin
            if (!in_cyc) begin
                in_cyc = 1'b1;
                wcnt   = (waitq.size() != 0) ? waitq.pop_front() : $urandom_range(0, 3);
            end
            if (wcnt == 0 && !slave_hold) begin
                wb_ack_i = 1'b1;
                wb_dat_i = mem(wb_adr_o);
                in_cyc   = 1'b0;
            end else begin
                wb_ack_i = 1'b0;
                wb_dat_i = $urandom;
                if (wcnt != 0) wcnt--;
            end
        end else begin
            // Acks outside a bus cycle must be ignored by the DUT.
            in_cyc   = 1'b0;
            wb_ack_i = spurious || ($urandom_range(0, 7) == 0);
            wb_dat_i = 32'hDEAD_BEEF;
        end
    end

    // ---------------- scoreboard + reference model ----------------
    typedef struct {
        logic [31:0] adr;
        logic [31:0] data;
    } exp_t;

    exp_t        sbq[$];
    exp_t        cur;
    logic        m_busy = 1'b0;
    logic        m_hold = 1'b0;
    logic [31:0] m_buf  = '0;
    logic        m_err  = 1'b0;
    int unsigned m_cnt  = 0;
    logic        prev_cyc = 1'b0;

    initial begin
        logic        ack_eff;
        logic        to_now;
        logic        exp_sr;
        logic [31:0] exp_dat;
        cur = '{adr: '0, data: '0};
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (wb_cyc_o && !prev_cyc) begin
                if (sbq.size() == 0) bound_fail("unexpected_bus_cycle");
                else cur = sbq.pop_front();
            end
            prev_cyc = wb_cyc_o;

            ack_eff = m_busy && wb_ack_i && !flush && !rst;
`ifdef IF_BUS_TIMEOUT_EN
            to_now = m_busy && !wb_ack_i && !flush && !rst && (m_cnt == TO - 1);
`else
            to_now = 1'b0;
`endif
            if (rst)         exp_sr = 1'b0;
            else if (m_busy) exp_sr = !wb_ack_i && !flush && !to_now;
            else             exp_sr = !m_hold && cpu_ce_i && !flush;
            if (rst)          exp_dat = '0;
            else if (ack_eff) exp_dat = cur.data;
            else if (m_hold)  exp_dat = m_buf;
            else              exp_dat = '0;

            chk("wb_cyc", 32'(wb_cyc_o), 32'(m_busy));
            chk("wb_stb", 32'(wb_stb_o), 32'(m_busy));
            chk("wb_sel", 32'(wb_sel_o), m_busy ? 32'hF : 32'h0);
            chk("wb_we", 32'(wb_we_o), 32'h0);
            if (m_busy) chk("wb_adr", wb_adr_o, cur.adr);
            chk("stallreq", 32'(stallreq_o), 32'(exp_sr));
            chk("cpu_data", cpu_data_o, exp_dat);
            chk("bus_err", 32'(bus_err_o), 32'(m_err));

            if (rst) begin
                m_busy = 1'b0;
                m_hold = 1'b0;
                m_err  = 1'b0;
                sbq.delete();
            end else begin
                m_err = to_now;
                if (m_busy) begin
                    if (flush) m_busy = 1'b0;
                    else if (wb_ack_i) begin
                        m_busy = 1'b0;
                        m_buf  = cur.data;
                        m_hold = (stall != 6'b0);
                    end else if (to_now) m_busy = 1'b0;
                    else m_cnt++;
                end else if (m_hold) begin
                    if (flush || stall == 6'b0) m_hold = 1'b0;
                end else if (cpu_ce_i && !flush) begin
                    sbq.push_back('{adr: {cpu_addr_i[31:2], 2'b00}, data: mem({cpu_addr_i[31:2], 2'b00})});
                    m_busy = 1'b1;
                    m_cnt  = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // mode: 0 normal, 1 flush while busy, 2 reset while busy, 3 never acked
    task automatic fetch(input logic [31:0] addr, input int unsigned waits,
                         input int unsigned hold, input logic [5:0] svec,
                         input int unsigned mode);
        int unsigned n;
        waitq.push_back(waits);
        slave_hold = (mode != 0);
        cpu_ce_i   = 1'b1;
        cpu_addr_i = addr;
        n = 0;
        do begin tick(); n++; end while (!wb_cyc_o && n < 20);
        if (!wb_cyc_o) begin
            bound_fail("launch_wait");
            cpu_ce_i   = 1'b0;
            slave_hold = 1'b0;
            return;
        end
        // Address changes while busy must not be sampled.
        cpu_addr_i = $urandom;
        cpu_ce_i   = (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        case (mode)
            0: begin
                n = 0;
                while (!wb_ack_i && n < 20) begin tick(); n++; end
                if (!wb_ack_i) begin
                    bound_fail("ack_wait");
                    cpu_ce_i = 1'b0;
                    return;
                end
                cpu_addr_i = $urandom;
                if (hold != 0) begin
                    stall    = svec;
                    cpu_ce_i = 1'b1;
                    repeat (hold) tick();
                    stall    = '0;
                    cpu_ce_i = 1'b0;
                end
            end
            1: begin
                repeat (waits) tick();
                flush = 1'b1;
                tick();
                flush    = 1'b0;
                spurious = 1'b1;
                tick();
                spurious   = 1'b0;
                slave_hold = 1'b0;
                tick();
            end
            2: begin
                repeat (waits) tick();
                rst = 1'b1;
                tick();
                rst        = 1'b0;
                slave_hold = 1'b0;
                tick();
            end
            default: begin
                n = 0;
                while (wb_cyc_o && n < 300) begin tick(); n++; end
                if (wb_cyc_o) bound_fail("timeout_wait");
                slave_hold = 1'b0;
                tick();
            end
        endcase
    endtask

    initial begin
        int unsigned mode;
        rst        = 1'b1;
        stall      = '0;
        flush      = 1'b0;
        cpu_ce_i   = 1'b0;
        cpu_addr_i = '0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        tick();

        fetch(32'h0000_0104, 0, 0, 6'b0, 0);
        fetch(32'h0000_0007, 3, 0, 6'b0, 0);
        fetch(32'h0000_0004, 0, 3, 6'b000111, 0);
        fetch(32'h0000_0200, 1, 0, 6'b0, 1);
        fetch(32'h0000_0300, 1, 0, 6'b0, 2);
`ifdef IF_BUS_TIMEOUT_EN
        fetch(32'h0000_0400, 0, 0, 6'b0, 3);
        fetch(32'h0000_0104, 0, 0, 6'b0, 0);
`endif

        repeat (250) begin
            mode = $urandom_range(0, 29);
            if (mode < 3)       mode = 1;
            else if (mode == 3) mode = 2;
`ifdef IF_BUS_TIMEOUT_EN
            else if (mode == 4) mode = 3;
`endif
            else                mode = 0;
            fetch($urandom, $urandom_range(0, 3),
                  ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                  6'($urandom_range(1, 63)), mode);
        end

        cpu_ce_i = 1'b0;
        repeat (5) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
